// File: rtl/pwm_cfg_sequencer.sv
// Sequencer that reprograms the PWM block over its register bus in a safe order:
// disable, inversion, mode parameters, enable. It then holds the new setting for a dwell time.
module pwm_cfg_sequencer #(
   parameter int BITS    = 32,
   parameter int DWELL_W = 32
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [2:0]         req_mode_i,
   input  logic               req_invert_i,
   input  logic [6*BITS-1:0]  req_param_i,
   input  logic [DWELL_W-1:0] req_dwell_i,
   input  logic               abort_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic               aborted_o,
   output logic               pwm_valid_o,
   output logic               pwm_we_o,
   output logic [BITS-1:0]    pwm_addr_o,
   output logic [BITS-1:0]    pwm_wdata_o,
   input  logic               pwm_ready_i
);

   // state   | meaning
   // S_IDLE  | waiting for a request, req_ready_o high
   // S_WRITE | walking the write list, step_q selects the entry
   // S_DWELL | holding the configuration, done when cnt_q reaches 0
   // S_ABORT | writing register 0 = 0 after an abort
   // S_DONE  | done pulse for an illegal mode or a completed abort
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_DWELL = 3'd2,
      S_ABORT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         mode_q;
   logic               inv_q;
   logic [BITS-1:0]    param_q [6];
   logic [DWELL_W-1:0] dwell_q, cnt_q;
   logic [3:0]         step_q;
   logic               abort_pend_q, err_q, abt_q;
   logic               valid_q;
   logic [BITS-1:0]    addr_q, wdata_q;

   logic               accept, wr_ack, abort_req, at_last;
   logic [3:0]         n_par, par_base, last_step, pidx, wr_reg;
   logic [BITS-1:0]    wr_data;
   logic               ld_zero, ld_next, drop, step_inc, ld_cnt, dec_cnt;

   assign accept    = req_valid_i && (state_q == S_IDLE);
   assign wr_ack    = valid_q && pwm_ready_i;
   assign abort_req = abort_i || abort_pend_q;
   assign at_last   = (step_q == last_step);

   always_comb begin
      n_par    = 4'd0;
      par_base = 4'd0;
      case (mode_q)
         3'd1:    begin n_par = 4'd3; par_base = 4'd2;  end
         3'd2:    begin n_par = 4'd6; par_base = 4'd5;  end
         3'd3:    begin n_par = 4'd5; par_base = 4'd11; end
         default: begin n_par = 4'd0; par_base = 4'd0;  end
      endcase
      last_step = n_par + 4'd2;
   end

   // Step 0 is the disable write; it shares the register-0-clear path with abort.
   always_comb begin
      wr_reg  = 4'd0;
      wr_data = '0;
      pidx    = step_q - 4'd2;
      if (step_q == 4'd1) begin
         wr_reg  = 4'd1;
         wr_data = BITS'(inv_q);
      end else if (step_q == last_step) begin
         wr_reg  = 4'd0;
         wr_data = BITS'(mode_q);
      end else if (step_q >= 4'd2) begin
         wr_reg = par_base + pidx;
         for (int i = 0; i < 6; i++) begin
            if (pidx == 4'(i)) wr_data = param_q[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      ld_zero  = 1'b0;
      ld_next  = 1'b0;
      drop     = 1'b0;
      step_inc = 1'b0;
      ld_cnt   = 1'b0;
      dec_cnt  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               if (req_mode_i[2]) begin
                  state_d = S_DONE;
               end else begin
                  ld_zero = 1'b1;
                  state_d = abort_i ? S_ABORT : S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (wr_ack) begin
               drop = 1'b1;
               if (abort_req) begin
                  state_d = S_ABORT;
               end else if (at_last) begin
                  state_d = S_DWELL;
                  ld_cnt  = 1'b1;
               end else begin
                  step_inc = 1'b1;
               end
            end else if (!valid_q) begin
               if (abort_req) begin
                  ld_zero = 1'b1;
                  state_d = S_ABORT;
               end else begin
                  ld_next = 1'b1;
               end
            end
         end
         S_DWELL: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else if (abort_i) begin
               ld_zero = 1'b1;
               state_d = S_ABORT;
            end else begin
               dec_cnt = 1'b1;
            end
         end
         S_ABORT: begin
            if (wr_ack) begin
               drop    = 1'b1;
               state_d = S_DONE;
            end else if (!valid_q) begin
               ld_zero = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = (state_q == S_IDLE);
      busy_o      = (state_q != S_IDLE);
      done_o      = (state_q == S_DONE) || ((state_q == S_DWELL) && (cnt_q == '0));
      err_o       = (state_q == S_DONE) && err_q;
      aborted_o   = (state_q == S_DONE) && abt_q;
      pwm_we_o    = valid_q;
   end

   assign pwm_valid_o = valid_q;
   assign pwm_addr_o  = addr_q;
   assign pwm_wdata_o = wdata_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q       <= '0;
         inv_q        <= 1'b0;
         dwell_q      <= '0;
         cnt_q        <= '0;
         step_q       <= '0;
         abort_pend_q <= 1'b0;
         err_q        <= 1'b0;
         abt_q        <= 1'b0;
         valid_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         for (int i = 0; i < 6; i++) param_q[i] <= '0;
      end else begin
         if (accept) begin
            mode_q       <= req_mode_i;
            inv_q        <= req_invert_i;
            dwell_q      <= req_dwell_i;
            cnt_q        <= '0;
            step_q       <= '0;
            abort_pend_q <= 1'b0;
            err_q        <= req_mode_i[2];
            abt_q        <= abort_i && !req_mode_i[2];
            for (int i = 0; i < 6; i++) param_q[i] <= req_param_i[i*BITS +: BITS];
         end else begin
            if (step_inc && !at_last) step_q <= step_q + 4'd1;
            if ((state_q == S_WRITE) && abort_i) abort_pend_q <= 1'b1;
            if ((state_q != S_ABORT) && (state_d == S_ABORT)) abt_q <= 1'b1;
            if (ld_cnt)                        cnt_q <= dwell_q;
            else if (dec_cnt && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
         end
         if (ld_zero) begin
            valid_q <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
         end else if (ld_next) begin
            valid_q <= 1'b1;
            addr_q  <= BITS'({wr_reg, 2'b00});
            wdata_q <= wr_data;
         end else if (drop) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Scoreboard bench for pwm_cfg_sequencer: a PWM slave model, a request-level
// reference model feeding expectation queues, and a monitor that checks bus writes and completions.
module tb_pwm_cfg_sequencer;
   localparam int BITS    = 32;
   localparam int DWELL_W = 32;

   logic               clk_i = 1'b0;
   logic               rst_ni = 1'b0;
   logic               req_valid_i = 1'b0;
   logic               req_ready_o;
   logic [2:0]         req_mode_i = '0;
   logic               req_invert_i = 1'b0;
   logic [6*BITS-1:0]  req_param_i = '0;
   logic [DWELL_W-1:0] req_dwell_i = '0;
   logic               abort_i = 1'b0;
   logic               busy_o, done_o, err_o, aborted_o;
   logic               pwm_valid_o, pwm_we_o;
   logic [BITS-1:0]    pwm_addr_o, pwm_wdata_o;
   logic               pwm_ready_i = 1'b0;

   pwm_cfg_sequencer #(.BITS(BITS), .DWELL_W(DWELL_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_mode_i(req_mode_i), .req_invert_i(req_invert_i),
      .req_param_i(req_param_i), .req_dwell_i(req_dwell_i),
      .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o), .aborted_o(aborted_o),
      .pwm_valid_o(pwm_valid_o), .pwm_we_o(pwm_we_o),
      .pwm_addr_o(pwm_addr_o), .pwm_wdata_o(pwm_wdata_o),
      .pwm_ready_i(pwm_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        err;
      logic        abt;
      logic [31:0] lat;
   } done_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          done_count = 0;
   logic [63:0] exp_wr_q[$];
   done_t       exp_done_q[$];
   logic [31:0] pwm_regs [16];
   int unsigned cur_p [6];
   int          np_tbl [4] = '{0, 3, 6, 5};
   int          base_tbl [4] = '{0, 2, 5, 11};

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // PWM slave: acknowledges each write one cycle after it sees valid
   initial begin
      int vcnt;
      vcnt = 0;
      forever begin
         @(posedge clk_i);
         #2;
         if (!rst_ni) begin
            pwm_ready_i = 1'b0;
            vcnt = 0;
         end else if (pwm_ready_i) begin
            pwm_ready_i = 1'b0;
         end else if (pwm_valid_o) begin
            if (vcnt == 1) begin
               pwm_ready_i = 1'b1;
               vcnt = 0;
            end else begin
               vcnt++;
            end
         end
      end
   end

   // Monitor: consumes expectations as the DUT presents writes and completions
   initial begin
      logic            prev_valid, post_ack, post_done, xact_active, start_xact;
      int              rise_cyc, last_evt;
      logic [31:0]     held_a, held_d;
      logic [63:0]     e;
      done_t           d;
      prev_valid = 0; post_ack = 0; post_done = 0; xact_active = 0; start_xact = 0;
      rise_cyc = 0; last_evt = 0; held_a = 0; held_d = 0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            prev_valid = 0; post_ack = 0; post_done = 0; xact_active = 0; start_xact = 0;
            exp_wr_q.delete();
            exp_done_q.delete();
         end else begin
            chk("we_follows_valid", 64'(pwm_we_o), 64'(pwm_valid_o));
            if (post_ack) begin
               chk("valid_drop_after_ack", 64'(pwm_valid_o), 64'd0);
               post_ack = 0;
            end
            if (pwm_valid_o && !prev_valid) begin
               rise_cyc = cyc;
               held_a = pwm_addr_o;
               held_d = pwm_wdata_o;
            end else if (pwm_valid_o) begin
               chk("addr_stable", 64'(pwm_addr_o), 64'(held_a));
               chk("wdata_stable", 64'(pwm_wdata_o), 64'(held_d));
            end
            if (pwm_valid_o && pwm_ready_i) begin
               chk("write_cycles", 64'(cyc + 1 - rise_cyc), 64'd2);
               if (exp_wr_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_write addr=%0h data=%0h", pwm_addr_o, pwm_wdata_o);
               end else begin
                  e = exp_wr_q.pop_front();
                  chk("wr_addr", 64'(pwm_addr_o), 64'(e[63:32]));
                  chk("wr_data", 64'(pwm_wdata_o), 64'(e[31:0]));
               end
               pwm_regs[pwm_addr_o[5:2]] = pwm_wdata_o;
               last_evt = cyc + 1;
               post_ack = 1;
            end
            prev_valid = pwm_valid_o;
            if (req_valid_i && req_ready_o) begin
               last_evt = cyc + 1;
               start_xact = 1;
            end
            if (post_done) begin
               chk("ready_after_done", 64'(req_ready_o), 64'd1);
               post_done = 0;
            end
            if (xact_active) begin
               chk("ready_low_while_busy", 64'(req_ready_o), 64'd0);
               chk("busy_high", 64'(busy_o), 64'd1);
            end
            if (done_o) begin
               if (exp_done_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_done err=%0b aborted=%0b", err_o, aborted_o);
               end else begin
                  d = exp_done_q.pop_front();
                  chk("done_err", 64'(err_o), 64'(d.err));
                  chk("done_aborted", 64'(aborted_o), 64'(d.abt));
                  chk("done_latency", 64'(cyc - last_evt), 64'(d.lat));
               end
               chk("writes_left_at_done", 64'(exp_wr_q.size()), 64'd0);
               done_count++;
               xact_active = 0;
               post_done = 1;
            end else begin
               chk("err_without_done", 64'(err_o), 64'd0);
               chk("aborted_without_done", 64'(aborted_o), 64'd0);
            end
            if (start_xact) begin
               xact_active = 1;
               start_xact = 0;
            end
         end
      end
   end

   // Reference model: akind 0=none, 1=abort during write k, 2=abort in dwell, 3=abort at accept
   task automatic push_exp(input int mode, input bit inv, input int dwell, input int akind, input int k);
      logic [63:0] lst[$];
      done_t       d;
      if (mode >= 4) begin
         d.err = 1'b1; d.abt = 1'b0; d.lat = 32'd0;
         exp_done_q.push_back(d);
         return;
      end
      lst.push_back({32'd0, 32'd0});
      lst.push_back({32'd4, 32'(inv)});
      for (int i = 0; i < np_tbl[mode]; i++)
         lst.push_back({32'((base_tbl[mode] + i) * 4), 32'(cur_p[i])});
      lst.push_back({32'd0, 32'(mode)});
      if (akind == 1) begin
         while (lst.size() > k) void'(lst.pop_back());
         lst.push_back(64'd0);
      end else if (akind == 2) begin
         lst.push_back(64'd0);
      end else if (akind == 3) begin
         lst.delete();
         lst.push_back(64'd0);
      end
      foreach (lst[i]) exp_wr_q.push_back(lst[i]);
      d.err = 1'b0;
      d.abt = (akind != 0);
      d.lat = (akind != 0) ? 32'd0 : 32'(dwell);
      exp_done_q.push_back(d);
   endtask

   task automatic send(input int mode, input bit inv, input int dwell, input bit abort_acc);
      int t;
      t = 0;
      @(posedge clk_i); #1;
      while (!req_ready_o && t < 2000) begin
         @(posedge clk_i); #1;
         t++;
      end
      chk("send_ready_in_time", 64'(t < 2000), 64'd1);
      req_mode_i   = mode[2:0];
      req_invert_i = inv;
      for (int i = 0; i < 6; i++) req_param_i[i*32 +: 32] = cur_p[i];
      req_dwell_i  = DWELL_W'(dwell);
      abort_i      = abort_acc;
      req_valid_i  = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i  = 1'b0;
      abort_i      = 1'b0;
      req_mode_i   = 3'($urandom);
      req_invert_i = 1'($urandom);
      for (int i = 0; i < 6; i++) req_param_i[i*32 +: 32] = $urandom;
      req_dwell_i  = DWELL_W'($urandom);
   endtask

   task automatic run_req(input int mode, input bit inv, input int dwell, input int akind, input int k);
      int start, t, seen, nwr;
      bit last_v;
      start = done_count;
      nwr = (mode < 4) ? 3 + np_tbl[mode] : 0;
      push_exp(mode, inv, dwell, akind, k);
      send(mode, inv, dwell, akind == 3);
      if (akind == 1) begin
         seen = 0; last_v = 0; t = 0;
         while (t < 500) begin
            if (pwm_valid_o && !last_v) seen++;
            last_v = pwm_valid_o;
            if (seen == k) break;
            @(posedge clk_i); #1;
            t++;
         end
         chk("abort_write_reached", 64'(t < 500), 64'd1);
         abort_i = 1'b1;
         @(posedge clk_i); #1;
         abort_i = 1'b0;
      end else if (akind == 2) begin
         seen = 0; last_v = 1; t = 0;
         while (seen < nwr && t < 500) begin
            @(posedge clk_i); #1;
            if (!pwm_valid_o && last_v) seen++;
            last_v = pwm_valid_o;
            t++;
         end
         chk("dwell_reached", 64'(t < 500), 64'd1);
         repeat (k - 1) begin
            @(posedge clk_i); #1;
         end
         abort_i = 1'b1;
         @(posedge clk_i); #1;
         abort_i = 1'b0;
      end
      t = 0;
      while (done_count == start && t < dwell + 500) begin
         @(posedge clk_i); #1;
         t++;
      end
      chk("done_in_time", 64'(t < dwell + 500), 64'd1);
   endtask

   initial begin
      int mode, dwell, akind, k, r, t;
      bit inv;
      foreach (pwm_regs[i]) pwm_regs[i] = '0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_req_ready", 64'(req_ready_o), 64'd1);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_aborted", 64'(aborted_o), 64'd0);
      chk("rst_pwm_valid", 64'(pwm_valid_o), 64'd0);
      chk("rst_pwm_we", 64'(pwm_we_o), 64'd0);
      chk("rst_pwm_addr", 64'(pwm_addr_o), 64'd0);
      chk("rst_pwm_wdata", 64'(pwm_wdata_o), 64'd0);
      rst_ni = 1'b1;

      cur_p = '{10, 100, 1, 0, 0, 0};
      run_req(1, 1'b1, 5, 0, 0);
      cur_p = '{1, 2, 3, 4, 5, 6};
      run_req(2, 1'b0, 0, 0, 0);
      chk("blink_final_reg0", 64'(pwm_regs[0]), 64'd2);
      run_req(6, 1'b0, 3, 0, 0);
      cur_p = '{7, 8, 9, 10, 11, 12};
      run_req(3, 1'b1, 4, 1, 3);
      cur_p = '{5, 50, 500, 0, 0, 0};
      run_req(1, 1'b0, 1000, 2, 10);
      run_req(2, 1'b1, 7, 3, 0);
      run_req(0, 1'b1, 2, 0, 0);

      // Reset in the middle of a write
      send(1, 1'b1, 3, 1'b0);
      t = 0;
      while (!pwm_valid_o && t < 100) begin
         @(posedge clk_i); #1;
         t++;
      end
      #2;
      rst_ni = 1'b0;
      #1;
      chk("midrst_valid", 64'(pwm_valid_o), 64'd0);
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_ready", 64'(req_ready_o), 64'd1);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      cur_p = '{3, 33, 333, 0, 0, 0};
      run_req(1, 1'b0, 3, 0, 0);

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 4) == 0) mode = $urandom_range(4, 7);
         else                           mode = $urandom_range(0, 3);
         inv   = 1'($urandom);
         dwell = $urandom_range(0, 12);
         for (int i = 0; i < 6; i++) cur_p[i] = $urandom;
         akind = 0;
         k     = 0;
         if (mode < 4) begin
            r = $urandom_range(0, 3);
            if (r == 1) begin
               akind = 1;
               k = $urandom_range(1, 3 + np_tbl[mode]);
            end else if (r == 2 && dwell >= 2) begin
               akind = 2;
               k = $urandom_range(1, dwell - 1);
            end else if (r == 3) begin
               akind = 3;
            end
         end
         run_req(mode, inv, dwell, akind, k);
      end

      repeat (3) @(posedge clk_i);
      chk("final_wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
      chk("final_done_queue_empty", 64'(exp_done_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
